// File: rtl/adder_share_arb.sv
// adder_share_arb: round-robin sharing of one fixed-latency wide adder among NUM_REQ requesters,
// with a requester tag pipeline that returns each sum in acceptance order.
module adder_share_arb #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W = 96,
    parameter int ADD_LATENCY = 3,
    parameter int CNT_W = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]         req_a,
    input  logic [NUM_REQ*DATA_W-1:0]         req_b,
    input  logic                              pause,
    output logic [DATA_W-1:0]                 add_dina,
    output logic [DATA_W-1:0]                 add_dinb,
    input  logic [DATA_W:0]                   add_dout,
    output logic                              rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]        rsp_id,
    output logic [DATA_W:0]                   rsp_data,
    output logic [$clog2(ADD_LATENCY+2):0]    inflight,
    output logic                              idle,
    output logic [CNT_W-1:0]                  issue_count
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int D = ADD_LATENCY + 1;
    localparam int FW = $clog2(ADD_LATENCY+2) + 1;
    logic [IW-1:0] ptr, gid, idx;
    logic hit, xfer;
    logic [D-1:0] tag_v;
    logic [IW-1:0] tag_id [D];
    // Scan downward so the last hit written is the nearest valid index at or above ptr.
    always_comb begin
        hit = 1'b0;
        gid = '0;
        idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = IW'((int'(ptr) + k) % NUM_REQ);
            if (req_valid[idx]) begin
                hit = 1'b1;
                gid = idx;
            end
        end
        xfer = hit && !pause && !rst;
        req_ready = xfer ? (NUM_REQ'(1) << gid) : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
            tag_v <= '0;
            for (int i = 0; i < D; i++) tag_id[i] <= '0;
            add_dina <= '0;
            add_dinb <= '0;
            inflight <= '0;
            issue_count <= '0;
        end else begin
            tag_v <= {tag_v[D-2:0], xfer};
            tag_id[0] <= gid;
            for (int i = 1; i < D; i++) tag_id[i] <= tag_id[i-1];
            add_dina <= xfer ? req_a[gid*DATA_W +: DATA_W] : '0;
            add_dinb <= xfer ? req_b[gid*DATA_W +: DATA_W] : '0;
            if (xfer) ptr <= (gid == IW'(NUM_REQ - 1)) ? '0 : gid + 1'b1;
            inflight <= inflight + {{(FW-1){1'b0}}, xfer} - {{(FW-1){1'b0}}, rsp_valid};
            if (xfer && !(&issue_count)) issue_count <= issue_count + 1'b1;
        end
    end
    assign rsp_valid = tag_v[D-1];
    assign rsp_id = tag_id[D-1];
    assign rsp_data = rsp_valid ? add_dout : '0;
    assign idle = (inflight == '0) && !xfer;
endmodule

// File: tb/tb_adder_share_arb.sv
// tb_adder_share_arb: directed and random stimulus against a transaction-level model
// (expected-response queue with due cycles); a behavioural adder stands in for the DSP.
module tb_adder_share_arb;
    localparam int NR = 4;
    localparam int DW = 96;
    localparam int LAT = 3;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pause = 1'b0;
    logic [NR-1:0] req_valid = '0;
    logic [NR*DW-1:0] req_a = '0, req_b = '0;
    logic [NR-1:0] req_ready, req_ready4;
    logic [DW-1:0] add_dina, add_dinb, dina4, dinb4;
    logic [DW:0] add_dout, rsp_data, rsp_data4;
    logic rsp_valid, rsp_valid4, idle, idle4;
    logic [1:0] rsp_id, rsp_id4;
    logic [3:0] inflight, inflight4;
    logic [31:0] issue_count;
    logic [3:0] issue_count4;
    logic [DW:0] pipe [LAT];

    typedef struct { int due; int id; logic [DW:0] sum; } rsp_t;
    rsp_t q[$];
    int cyc = 0, mptr = 0, mcnt = 0, n_cmp = 0, n_fail = 0;
    logic [DW-1:0] ea = '0, eb = '0;

    adder_share_arb dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .pause(pause),
        .add_dina(add_dina), .add_dinb(add_dinb), .add_dout(add_dout),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .inflight(inflight), .idle(idle), .issue_count(issue_count)
    );
    adder_share_arb #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready4),
        .req_a(req_a), .req_b(req_b), .pause(pause),
        .add_dina(dina4), .add_dinb(dinb4), .add_dout(add_dout),
        .rsp_valid(rsp_valid4), .rsp_id(rsp_id4), .rsp_data(rsp_data4),
        .inflight(inflight4), .idle(idle4), .issue_count(issue_count4)
    );

    always #5 clk = ~clk;

    // Adder samples its inputs and updates dout LAT edges later; it has no reset.
    always @(posedge clk) begin
        pipe[0] <= {1'b0, add_dina} + {1'b0, add_dinb};
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign add_dout = pipe[LAT-1];

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: check all outputs against the model, then advance the model and the clock.
    task automatic cycle();
        int g;
        logic [NR-1:0] er;
        #1;
        g = -1;
        if (!rst && !pause)
            for (int k = 0; k < NR; k++)
                if (g < 0 && req_valid[(mptr + k) % NR]) g = (mptr + k) % NR;
        er = (g >= 0) ? NR'(1 << g) : '0;
        chk("req_ready", 128'(req_ready), 128'(er));
        chk("req_ready_c4", 128'(req_ready4), 128'(er));
        chk("inflight", 128'(inflight), 128'(q.size()));
        chk("idle", 128'(idle), 128'(q.size() == 0 && g < 0));
        chk("issue_count", 128'(issue_count), 128'(mcnt));
        chk("issue_count_sat", 128'(issue_count4), 128'(mcnt > 15 ? 15 : mcnt));
        chk("add_dina", 128'(add_dina), 128'(ea));
        chk("add_dinb", 128'(add_dinb), 128'(eb));
        if (q.size() > 0 && q[0].due == cyc) begin
            chk("rsp_valid", 128'(rsp_valid), 128'(1));
            chk("rsp_id", 128'(rsp_id), 128'(q[0].id));
            chk("rsp_data", 128'(rsp_data), 128'(q[0].sum));
            void'(q.pop_front());
        end else
            chk("rsp_valid", 128'(rsp_valid), 128'(0));
        if (rst) begin
            q.delete();
            mptr = 0;
            mcnt = 0;
            ea = '0;
            eb = '0;
        end else if (g >= 0) begin
            ea = req_a[g*DW +: DW];
            eb = req_b[g*DW +: DW];
            q.push_back('{cyc + 1 + LAT, g, {1'b0, ea} + {1'b0, eb}});
            mptr = (g + 1) % NR;
            mcnt++;
        end else begin
            ea = '0;
            eb = '0;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        pause = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    task automatic idle_cycles(int n);
        req_valid = '0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        // Registers are unknown before the first reset edge.
        @(posedge clk);
        @(negedge clk);
        do_reset();
        cycle();
        // Single op on requester 2, carry out of bit 95.
        req_a[2*DW +: DW] = {DW{1'b1}};
        req_b[2*DW +: DW] = 96'd1;
        req_valid = 4'b0100;
        cycle();
        idle_cycles(6);
        // Carry across the 48-bit boundary.
        req_a[0 +: DW] = 96'h0000_0000_0000_FFFF_FFFF_FFFF;
        req_b[0 +: DW] = 96'd1;
        req_valid = 4'b0001;
        cycle();
        idle_cycles(6);
        // All requesters valid for 12 cycles: strict rotation, inflight peaks at 4.
        do_reset();
        for (int i = 0; i < NR; i++) begin
            req_a[i*DW +: DW] = DW'(i);
            req_b[i*DW +: DW] = 96'd100;
        end
        req_valid = 4'b1111;
        for (int i = 0; i < 12; i++) cycle();
        idle_cycles(6);
        // Pause after the first grant; pointer holds, in-flight result still emerges.
        do_reset();
        req_valid = 4'b1010;
        cycle();
        pause = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        pause = 1'b0;
        cycle();
        idle_cycles(6);
        // Reset with three operations in flight: none of them may respond.
        do_reset();
        req_valid = 4'b0111;
        for (int i = 0; i < 3; i++) cycle();
        do_reset();
        cycle();
        req_valid = 4'b0110;
        cycle();
        idle_cycles(6);
        // Saturation of the 4-bit counter.
        do_reset();
        req_valid = 4'b1111;
        for (int i = 0; i < 17; i++) cycle();
        idle_cycles(6);
        // Random traffic with random operands and occasional pause.
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < NR; i++) begin
                req_a[i*DW +: DW] = {$urandom(), $urandom(), $urandom()};
                req_b[i*DW +: DW] = {$urandom(), $urandom(), $urandom()};
            end
            req_valid = NR'($urandom());
            pause = ($urandom_range(7) == 0);
            cycle();
        end
        pause = 1'b0;
        idle_cycles(6);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
